// File: rtl/regfile_bist.sv
// BIST controller for the 8x16 regfile: writes a per-register pattern, reads it back, reports errors.
// Optional inverted second pass is enabled by defining REGFILE_BIST_INV_PASS_EN.
module regfile_bist (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] pattern,
    output logic [15:0] data_in,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [2:0]  readnum,
    input  logic [15:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  fail_reg,
    output logic [3:0]  fail_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
`ifdef REGFILE_BIST_INV_PASS_EN
    localparam logic [2:0] S_WR2  = 3'd3;
    localparam logic [2:0] S_RD2  = 3'd4;
`endif
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  r_n;
    logic [15:0] r_pat;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [2:0]  r_fail_reg;
    logic [3:0]  r_fail_cnt;

    logic [2:0]  w_next;
    logic        w_inv;
    logic        w_in_wr;
    logic        w_in_rd;
    logic        w_last;
    logic        w_accept;
    logic        w_mismatch;
    logic [15:0] w_p;
    logic [15:0] w_exp;

`ifdef REGFILE_BIST_INV_PASS_EN
    assign w_inv   = (r_state == S_WR2) || (r_state == S_RD2);
    assign w_in_wr = (r_state == S_WR)  || (r_state == S_WR2);
    assign w_in_rd = (r_state == S_RD)  || (r_state == S_RD2);
`else
    assign w_inv   = 1'b0;
    assign w_in_wr = (r_state == S_WR);
    assign w_in_rd = (r_state == S_RD);
`endif

    assign w_p        = w_inv ? ~r_pat : r_pat;
    assign w_exp      = {w_p[15:3], w_p[2:0] ^ r_n};
    assign w_last     = (r_n == 3'd7);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_mismatch = w_in_rd && (data_out != w_exp);

    // Regfile port drive decodes straight from state and n so that reset drops write immediately.
    assign write    = w_in_wr;
    assign writenum = w_in_wr ? r_n : 3'd0;
    assign data_in  = w_in_wr ? w_exp : 16'd0;
    assign readnum  = w_in_rd ? r_n : 3'd0;

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign fail_reg = r_fail_reg;
    assign fail_cnt = r_fail_cnt;

    // NOTE: w_next gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_WR;
            S_WR:    if (w_last) w_next = S_RD;
`ifdef REGFILE_BIST_INV_PASS_EN
            S_RD:    if (w_last) w_next = S_WR2;
            S_WR2:   if (w_last) w_next = S_RD2;
            S_RD2:   if (w_last) w_next = S_FIN;
`else
            S_RD:    if (w_last) w_next = S_FIN;
`endif
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_n        <= 3'd0;
            r_pat      <= 16'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_fail_reg <= 3'd0;
            r_fail_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_FIN);
            // n restarts at 0 on every state entry and only advances inside a pass
            if ((w_in_wr || w_in_rd) && (w_next == r_state))
                r_n <= r_n + 3'd1;
            else
                r_n <= 3'd0;

            if (w_accept) begin
                r_pat      <= pattern;
                r_err      <= 1'b0;
                r_fail_reg <= 3'd0;
                r_fail_cnt <= 4'd0;
            end else if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_fail_cnt != 4'd15)
                    r_fail_cnt <= r_fail_cnt + 4'd1;
                if (!r_err)
                    r_fail_reg <= r_n;
            end
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Directed self-checking bench for regfile_bist with a behavioural 8x16 regfile and read-fault injection.
module tb_regfile_bist;

`ifdef REGFILE_BIST_INV_PASS_EN
    localparam int DONE_CYC = 33;
    localparam int WR_CNT   = 16;
    localparam int F5_CNT   = 2;
    localparam int F36_CNT  = 4;
    localparam int LIMIT    = 80;
`else
    localparam int DONE_CYC = 17;
    localparam int WR_CNT   = 8;
    localparam int F5_CNT   = 1;
    localparam int F36_CNT  = 2;
    localparam int LIMIT    = 45;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] pattern;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic [15:0] data_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  fail_reg;
    logic [3:0]  fail_cnt;

    logic [15:0] regs [8];
    logic [7:0]  fault_mask;
    logic        clr_regs;

    int n_cmp;
    int n_bad;

    int          first_done, second_done, n_done, n_busy, n_wr;
    logic        s1_write, s9_write;
    logic [2:0]  s1_wn, s9_rn;
    logic [15:0] s1_di;

    logic [15:0] exp_tab [8];

    regfile_bist dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .pattern  (pattern),
        .data_in  (data_in),
        .writenum (writenum),
        .write    (write),
        .readnum  (readnum),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .fail_reg (fail_reg),
        .fail_cnt (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_regs) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    always_comb data_out = fault_mask[readnum] ? 16'h0000 : regs[readnum];

    // Launches one run from IDLE and records what happens at each negedge over LIMIT cycles.
    task automatic run(input logic [15:0] p, input int pulse_cyc, input bit hold);
        first_done = 0; second_done = 0; n_done = 0; n_busy = 0; n_wr = 0;
        @(negedge clk);
        start   = 1'b1;
        pattern = p;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                s1_write = write; s1_wn = writenum; s1_di = data_in;
                pattern  = ~p;
                if (!hold) start = 1'b0;
            end
            if (k == 9) begin
                s9_write = write; s9_rn = readnum;
            end
            if (busy)  n_busy++;
            if (write) n_wr++;
            if (done) begin
                n_done++;
                if (n_done == 1) first_done = k;
                if (n_done == 2) begin
                    second_done = k;
                    start = 1'b0;
                end
            end
            if (pulse_cyc != 0 && k == pulse_cyc)     start = 1'b1;
            if (pulse_cyc != 0 && k == pulse_cyc + 1) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (write    !== 1'b0)  begin n_bad++; $display("FAIL reset_write: got %0b want 0", write); end
        n_cmp++; if (writenum !== 3'd0)  begin n_bad++; $display("FAIL reset_writenum: got %0d want 0", writenum); end
        n_cmp++; if (data_in  !== 16'h0) begin n_bad++; $display("FAIL reset_data_in: got %h want 0000", data_in); end
        n_cmp++; if (readnum  !== 3'd0)  begin n_bad++; $display("FAIL reset_readnum: got %0d want 0", readnum); end
        n_cmp++; if (busy     !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (done     !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
        n_cmp++; if (err      !== 1'b0)  begin n_bad++; $display("FAIL reset_err: got %0b want 0", err); end
        n_cmp++; if (fail_reg !== 3'd0)  begin n_bad++; $display("FAIL reset_fail_reg: got %0d want 0", fail_reg); end
        n_cmp++; if (fail_cnt !== 4'd0)  begin n_bad++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_abcd;
`ifdef REGFILE_BIST_INV_PASS_EN
        exp_tab = '{16'h5432, 16'h5433, 16'h5430, 16'h5431, 16'h5436, 16'h5437, 16'h5434, 16'h5435};
`else
        exp_tab = '{16'hABCD, 16'hABCC, 16'hABCF, 16'hABCE, 16'hABC9, 16'hABC8, 16'hABCB, 16'hABCA};
`endif
        run(16'hABCD, 0, 1'b0);
        n_cmp++; if (first_done !== DONE_CYC) begin n_bad++; $display("FAIL abcd_done_cycle: got %0d want %0d", first_done, DONE_CYC); end
        n_cmp++; if (n_done !== 1)            begin n_bad++; $display("FAIL abcd_done_count: got %0d want 1", n_done); end
        n_cmp++; if (n_busy !== DONE_CYC)     begin n_bad++; $display("FAIL abcd_busy_cycles: got %0d want %0d", n_busy, DONE_CYC); end
        n_cmp++; if (n_wr !== WR_CNT)         begin n_bad++; $display("FAIL abcd_write_cycles: got %0d want %0d", n_wr, WR_CNT); end
        n_cmp++; if ({s1_write, s1_wn, s1_di} !== {1'b1, 3'd0, 16'hABCD})
            begin n_bad++; $display("FAIL abcd_cycle1_port: got w=%0b n=%0d d=%h want w=1 n=0 d=abcd", s1_write, s1_wn, s1_di); end
        n_cmp++; if ({s9_write, s9_rn} !== {1'b0, 3'd0})
            begin n_bad++; $display("FAIL abcd_cycle9_port: got w=%0b rn=%0d want w=0 rn=0", s9_write, s9_rn); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (regs[i] !== exp_tab[i]) begin n_bad++; $display("FAIL abcd_reg%0d: got %h want %h", i, regs[i], exp_tab[i]); end
        end
        n_cmp++; if ({err, fail_cnt, fail_reg} !== 8'd0)
            begin n_bad++; $display("FAIL abcd_status: got err=%0b cnt=%0d reg=%0d want 0/0/0", err, fail_cnt, fail_reg); end
    endtask

    task automatic test_pattern_zero;
`ifdef REGFILE_BIST_INV_PASS_EN
        exp_tab = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8};
`else
        exp_tab = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
`endif
        run(16'h0000, 0, 1'b0);
        n_cmp++; if (first_done !== DONE_CYC) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want %0d", first_done, DONE_CYC); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (regs[i] !== exp_tab[i]) begin n_bad++; $display("FAIL zero_reg%0d: got %h want %h", i, regs[i], exp_tab[i]); end
        end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL zero_err: got %0b want 0", err); end
    endtask

    task automatic test_fault_r5;
        fault_mask = 8'b0010_0000;
        run(16'h1234, 0, 1'b0);
        n_cmp++; if (err !== 1'b1)        begin n_bad++; $display("FAIL f5_err: got %0b want 1", err); end
        n_cmp++; if (fail_reg !== 3'd5)   begin n_bad++; $display("FAIL f5_fail_reg: got %0d want 5", fail_reg); end
        n_cmp++; if (fail_cnt !== F5_CNT) begin n_bad++; $display("FAIL f5_fail_cnt: got %0d want %0d", fail_cnt, F5_CNT); end
        fault_mask = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if ({err, fail_reg} !== {1'b1, 3'd5})
            begin n_bad++; $display("FAIL f5_sticky: got err=%0b reg=%0d want 1/5", err, fail_reg); end
    endtask

    task automatic test_fault_r3_r6;
        fault_mask = 8'b0100_1000;
        run(16'h1234, 0, 1'b0);
        n_cmp++; if (err !== 1'b1)         begin n_bad++; $display("FAIL f36_err: got %0b want 1", err); end
        n_cmp++; if (fail_reg !== 3'd3)    begin n_bad++; $display("FAIL f36_fail_reg: got %0d want 3", fail_reg); end
        n_cmp++; if (fail_cnt !== F36_CNT) begin n_bad++; $display("FAIL f36_fail_cnt: got %0d want %0d", fail_cnt, F36_CNT); end
        fault_mask = 8'h00;
    endtask

    task automatic test_ignore_start;
        run(16'hABCD, 12, 1'b0);
        n_cmp++; if (first_done !== DONE_CYC) begin n_bad++; $display("FAIL ign_done_cycle: got %0d want %0d", first_done, DONE_CYC); end
        n_cmp++; if (n_done !== 1)            begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", n_done); end
        n_cmp++; if ({err, fail_cnt, fail_reg} !== 8'd0)
            begin n_bad++; $display("FAIL ign_status_cleared: got err=%0b cnt=%0d reg=%0d want 0/0/0", err, fail_cnt, fail_reg); end
    endtask

    task automatic test_back_to_back;
        run(16'h0F0F, 0, 1'b1);
        n_cmp++; if (first_done !== DONE_CYC)
            begin n_bad++; $display("FAIL b2b_first_done: got %0d want %0d", first_done, DONE_CYC); end
        n_cmp++; if (second_done !== 2 * DONE_CYC + 1)
            begin n_bad++; $display("FAIL b2b_second_done: got %0d want %0d", second_done, 2 * DONE_CYC + 1); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: got busy=%0b want 0", busy); end
    endtask

    task automatic test_reset_mid_run;
        int bad_wr;
        exp_tab = '{16'h5555, 16'h5554, 16'h5557, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        @(negedge clk); clr_regs = 1'b1;
        @(negedge clk); clr_regs = 1'b0;
        start = 1'b1; pattern = 16'h5555;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({write, writenum, data_in, readnum, busy, done, err, fail_reg, fail_cnt} !== 33'd0)
            begin n_bad++; $display("FAIL rst_mid_outputs: got w=%0b busy=%0b done=%0b din=%h want all 0", write, busy, done, data_in); end
        bad_wr = 0;
        repeat (3) begin
            @(negedge clk);
            if (write !== 1'b0) bad_wr++;
        end
        n_cmp++; if (bad_wr !== 0) begin n_bad++; $display("FAIL rst_mid_write_low: got %0d cycles with write want 0", bad_wr); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (regs[i] !== exp_tab[i]) begin n_bad++; $display("FAIL rst_mid_reg%0d: got %h want %h", i, regs[i], exp_tab[i]); end
        end
        reset_n = 1'b1;
        @(negedge clk);
        run(16'h5555, 0, 1'b0);
        n_cmp++; if (first_done !== DONE_CYC) begin n_bad++; $display("FAIL rst_rerun_done: got %0d want %0d", first_done, DONE_CYC); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_rerun_err: got %0b want 0", err); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        start = 1'b0; pattern = 16'h0000; fault_mask = 8'h00; clr_regs = 1'b0;
        test_reset;
        test_basic_abcd;
        test_pattern_zero;
        test_fault_r5;
        test_fault_r3_r6;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test controller that drives the write and read ports of the 8×16-bit `regfile`. On `start` it writes a per-register pattern into R0..R7, reads every register back, compares the result and reports pass/fail. It sits beside `regfile` in the lab datapath and owns the regfile port mux while `busy` is high.

## Interface

- No parameters. Widths are fixed to match `regfile`: 16-bit data and 3-bit register index.
- `clk` input 1: rising-edge clock, shared with `regfile`.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a test run. Sampled only in IDLE.
- `pattern` input 16: base test word, latched on the accepted `start`.
- `data_in` output 16: to `regfile.data_in`.
- `writenum` output 3: to `regfile.writenum`.
- `write` output 1: to `regfile.write`.
- `readnum` output 3: to `regfile.readnum`.
- `data_out` input 16: from `regfile.data_out`. Must be combinational in `readnum`.
- `busy` output 1: test in progress.
- `done` output 1: one-cycle pulse at end of run.
- `err` output 1: at least one mismatch in the last run. Sticky until the next accepted `start`.
- `fail_reg` output 3: index of the first mismatching register. 0 if none.
- `fail_cnt` output 4: mismatch count for the run, saturating at 15.
- Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation

- States: IDLE, WR, RD, FIN. With the macro: IDLE, WR, RD, WR2, RD2, FIN.
- 3-bit counter `n` indexes the register under test. It resets to 0 on every state entry.
- Expected value for register n: `exp(n) = {p[15:3], p[2:0] ^ n}`.
  - `p` is the latched pattern in WR/RD.
  - `p` is `~pattern_latched` in WR2/RD2.
- IDLE: all port outputs are 0. If `start`=1 at an edge:
  - latch `pattern`;
  - clear `err`, `fail_reg` and `fail_cnt`;
  - go to WR.
- WR: `write`=1, `writenum`=n, `data_in`=exp(n). After n=7 go to RD (or WR2 path as below).
- RD: `write`=0, `readnum`=n. At each edge compare `data_out` against exp(n). On mismatch:
  - set `err`;
  - increment `fail_cnt`, saturating at 15;
  - record n into `fail_reg` only if `err` was 0 before this edge.
  - After n=7: go to FIN, or to WR2 if the macro is defined.
- WR2/RD2: same as WR/RD using the inverted pattern. The error state accumulates across passes.
- FIN: `done`=1 for exactly one cycle, then return to IDLE. `err`, `fail_reg` and `fail_cnt` hold until the next accepted `start`.
- `start` while not in IDLE is ignored. `start` held high re-triggers a new run from IDLE on the cycle after FIN.
- `pattern` changes after acceptance have no effect.

## Timing

- Reset values: state IDLE, n=0, and every output 0. This includes `data_in`, `writenum`, `write`, `readnum`, `busy`, `done`, `err`, `fail_reg` and `fail_cnt`.
- Reset mid-run: immediate return to IDLE and `write` drops at once. No further regfile writes occur. Registers already written keep their values.
- `start` accepted at edge E0:
  - `busy`=1 from E0 until the edge that leaves FIN;
  - WR occupies cycles 1–8;
  - RD occupies cycles 9–16;
  - `done` is high in cycle 17.
- With the macro: WR2 occupies cycles 17–24, RD2 cycles 25–32, and `done` is high in cycle 33.
- The write to Rn commits on the edge that ends WR cycle n. R7 is therefore valid before the first RD cycle. There is no idle bubble between WR and RD.
- The read is compared in the same cycle `readnum` is driven. The regfile read path must settle within one period.
- All outputs are registered except `write`, `writenum`, `readnum` and `data_in`. These four decode directly from state and n and are glitch-free at clock edges.

## Configuration

- `REGFILE_BIST_INV_PASS_EN`
  - Defined: a second write/read pass with the bitwise-inverted pattern is added. Every bit of every register is tested at both polarities. Run length is 32 cycles plus FIN.
  - Undefined: single pass only. WR2/RD2 do not exist. Run length is 16 cycles plus FIN.
- Port list is identical in both builds.

## Test plan

- Reset released, `pattern`=16'hABCD, `start` pulse → R0..R7 hold ABCD, ABCC, ABCF, ABCE, ABC9, ABC8, ABCB, ABCA. `done` high in cycle 17. `err`=0, `fail_cnt`=0.
- Macro defined, `pattern`=16'h0000 → R0..R7 end as FFFF, FFFE, FFFD, FFFC, FFFB, FFFA, FFF9, FFF8. `done` high in cycle 33. `err`=0.
- Bench forces `data_out` to 16'h0000 whenever `readnum`=5, `pattern`=16'h1234 → `err`=1, `fail_reg`=5, `fail_cnt`=1.
- Bench forces `data_out` to 16'h0000 whenever `readnum` is 3 or 6, with the macro defined → `fail_reg`=3, `fail_cnt`=4.
- Assert `reset_n`=0 during WR cycle 4, release, then `start` with `pattern`=16'h5555 → `write` is 0 throughout reset and all outputs read 0. The new run completes with `err`=0.
- `start` pulsed again in RD cycle 12 → ignored. `done` still occurs exactly once, in cycle 17.
